// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of every bus signal around the data-memory arbiter.
//   core_*  : pipeline MEM-stage request (StallM back to the hazard unit)
//   ext_*   : external master request/response (valid/ready + registered read)
//   mem_*   : single-port dmem side (combinational read on mem_rd)
// Modports:
//   slave  : the arbiter's view
//   master : the requesters' + memory's view (core, external master, dmem)
interface dmem_arbiter_if;
  logic        core_req;
  logic        core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        StallM;

  logic        ext_valid;
  logic        ext_ready;
  logic        ext_we;
  logic [3:0]  ext_be;
  logic [31:0] ext_addr;
  logic [31:0] ext_wd;
  logic [31:0] ext_rdata;
  logic        ext_rvalid;

  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  core_req, core_we, core_be, core_addr, core_wd,
    output core_rd, StallM,
    input  ext_valid, ext_we, ext_be, ext_addr, ext_wd,
    output ext_ready, ext_rdata, ext_rvalid,
    output mem_we, mem_be, mem_addr, mem_wd,
    input  mem_rd
  );

  modport master (
    output core_req, core_we, core_be, core_addr, core_wd,
    input  core_rd, StallM,
    output ext_valid, ext_we, ext_be, ext_addr, ext_wd,
    input  ext_ready, ext_rdata, ext_rvalid,
    input  mem_we, mem_be, mem_addr, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between the core MEM stage and an
// external master. Core has priority; a starvation counter forces an external
// grant after STARVE_LIMIT consecutive contended core wins. External reads
// return through a registered response one cycle after the transfer.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : dmem_arbiter_if.slave (core_*, ext_*, mem_* groups)
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);
  // $clog2(1) is 0 for STARVE_LIMIT=0; keep at least one bit so the
  // counter stays a legal vector (it never leaves 0 in that case).
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] wait_cnt;
  logic          grant_ext;
  logic          grant_core;

  assign grant_ext  = !reset && bus.ext_valid && (!bus.core_req || wait_cnt == LIMIT);
  assign grant_core = !reset && bus.core_req && !grant_ext;

  assign bus.ext_ready = grant_ext;
  assign bus.StallM    = bus.core_req && grant_ext;
  assign bus.core_rd   = bus.mem_rd;

  // Address/data follow the core whenever the external port is not granted;
  // only the write strobe needs to be qualified by a grant.
  assign bus.mem_we   = (grant_ext && bus.ext_we) || (grant_core && bus.core_we);
  assign bus.mem_be   = grant_ext ? bus.ext_be   : bus.core_be;
  assign bus.mem_addr = grant_ext ? bus.ext_addr : bus.core_addr;
  assign bus.mem_wd   = grant_ext ? bus.ext_wd   : bus.core_wd;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt       <= '0;
      bus.ext_rvalid <= 1'b0;
      bus.ext_rdata  <= '0;
    end else begin
      // Clear has priority: a dropped ext_valid never leaves a stale count.
      if (grant_ext || !bus.ext_valid)
        wait_cnt <= '0;
      else if (bus.core_req && grant_core && wait_cnt != LIMIT)
        wait_cnt <= wait_cnt + 1'b1;

      bus.ext_rvalid <= grant_ext && !bus.ext_we;
      if (grant_ext && !bus.ext_we)
        bus.ext_rdata <= bus.mem_rd;
    end
  end
endmodule
